// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_pkg
// Description : Shared widths, saturation limits and the shaper configuration
//               record used by the FIR output shaping stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

  // Full-precision FIR sum width (tap width + data width) and narrow output width
  localparam int FIR_SUM_WIDTH   = 48;
  localparam int FIR_OUT_WIDTH   = 16;

  // Config field widths carried by shaper_cfg_t
  localparam int FIR_SHIFT_WIDTH = 6;
  localparam int FIR_DECIM_WIDTH = 8;

  // Two's-complement limits of the narrow output word
  localparam logic signed [FIR_OUT_WIDTH-1:0] FIR_OUT_MAX = {1'b0, {(FIR_OUT_WIDTH-1){1'b1}}};
  localparam logic signed [FIR_OUT_WIDTH-1:0] FIR_OUT_MIN = {1'b1, {(FIR_OUT_WIDTH-1){1'b0}}};

  // Shadowed shaping configuration
  typedef struct packed {
    logic [FIR_SHIFT_WIDTH-1:0] shift;
    logic [FIR_DECIM_WIDTH-1:0] decim;
  } shaper_cfg_t;

endpackage
`default_nettype wire

// File: rtl/fir_shaper_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fir_shaper_fifo
// Description : Synchronous first-word-fall-through FIFO with occupancy count.
//               The head word is visible on rd_data_o whenever valid_o is high;
//               rd_en_i pops it. Reads of an empty FIFO are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_shaper_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4,
  localparam int PTR_W     = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  valid_o,
  output logic [PTR_W:0]        count_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [PTR_W:0]        count_q;
  logic                  w_rd;
  logic                  w_full;

  // A pop only happens when there is a word to pop
  assign w_rd   = rd_en_i && (count_q != '0);
  assign w_full = (count_q == (PTR_W+1)'(DEPTH));

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n)
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en_i) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (w_rd) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({wr_en_i, w_rd})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Head word is forced to zero while empty so the output bus is clean after reset
  assign valid_o   = (count_q != '0);
  assign rd_data_o = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o   = count_q;

  // The upstream credit scheme must make a write into a full FIFO impossible
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
                                  !(wr_en_i && w_full && !w_rd));

endmodule
`default_nettype wire

// File: rtl/fir_dout_shaper.sv
`default_nettype none
// ============================================================================
// Module      : fir_dout_shaper
// Description : FIR output shaper. Per accepted sample: optional 1-of-(N+1)
//               decimation, round-half-up, arithmetic right shift and
//               saturation to OUT_WIDTH, then a small FWFT FIFO towards an
//               AXI-Stream master. Upstream tready is registered and driven
//               by a credit count, never combinationally from downstream.
//               Optional macro FIR_DOUT_SHAPER_STAT_EN adds a 16-bit
//               saturation event counter on sat_cnt_o.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_dout_shaper
  import fir_pkg::*;
#(
  parameter int IN_WIDTH    = FIR_SUM_WIDTH,
  parameter int OUT_WIDTH   = FIR_OUT_WIDTH,
  parameter int SHIFT_WIDTH = FIR_SHIFT_WIDTH,
  parameter int DECIM_WIDTH = FIR_DECIM_WIDTH,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   cfg_load_i,
  input  logic [SHIFT_WIDTH-1:0] shift_cfg_i,
  input  logic [DECIM_WIDTH-1:0] decim_cfg_i,
  input  logic [IN_WIDTH-1:0]    s_axis_tdata_i,
  input  logic                   s_axis_tvalid_i,
  output logic                   s_axis_tready_o,
  output logic [OUT_WIDTH-1:0]   m_axis_tdata_o,
  output logic                   m_axis_tvalid_o,
  input  logic                   m_axis_tready_i,
  output logic                   sat_flag_o
`ifdef FIR_DOUT_SHAPER_STAT_EN
  ,
  output logic [15:0]            sat_cnt_o
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;   // FIFO occupancy width
  localparam int CRD_W = CNT_W + 1;                // occupancy + in-flight headroom

  // Saturation limits expressed at the internal IN_WIDTH+1 precision
  localparam logic signed [IN_WIDTH:0] SAT_MAX =
    {{(IN_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [IN_WIDTH:0] SAT_MIN =
    {{(IN_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  localparam logic signed [IN_WIDTH:0] RND_ONE = {{IN_WIDTH{1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  shaper_cfg_t             cfg_q;
  logic [DECIM_WIDTH-1:0]  dcnt_q, dcnt_d;
  logic                    s_tready_q, s_tready_d;

  logic                    s1_valid_q;
  logic signed [IN_WIDTH:0] s1_sum_q;
  logic [SHIFT_WIDTH-1:0]  s1_shift_q;

  logic                    s2_valid_q;
  logic [OUT_WIDTH-1:0]    s2_data_q;

  logic                    sat_flag_q;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic                     w_xfer;
  logic                     w_keep;
  logic signed [IN_WIDTH:0] w_round;
  logic signed [IN_WIDTH:0] w_sum;
  logic signed [IN_WIDTH:0] w_shifted;
  logic                     w_hi;
  logic                     w_lo;
  logic                     w_clip;
  logic                     w_rd;
  logic [CNT_W-1:0]         w_fifo_cnt;
  logic [CRD_W-1:0]         w_credit;

  assign w_xfer = s_axis_tvalid_i && s_tready_q;
  // The first transfer after reset or a config load always sees dcnt_q == 0
  assign w_keep = w_xfer && (dcnt_q == '0);

  // Round-half-up constant and the widened sum for stage 1
  always_comb begin
    w_round = '0;
    if (cfg_q.shift != '0) begin
      w_round = RND_ONE << (cfg_q.shift - SHIFT_WIDTH'(1));
    end
    w_sum = $signed({s_axis_tdata_i[IN_WIDTH-1], s_axis_tdata_i}) + w_round;
  end

  // Stage-2 shift and clip detection; the shift travels with the sample
  assign w_shifted = s1_sum_q >>> s1_shift_q;
  assign w_hi      = (w_shifted > SAT_MAX);
  assign w_lo      = (w_shifted < SAT_MIN);
  assign w_clip    = s1_valid_q && (w_hi || w_lo);

  // Next decimation count: a load restarts the phase; the same-edge sample
  // was judged against the old count and does not advance the new one
  always_comb begin
    dcnt_d = dcnt_q;
    if (cfg_load_i) begin
      dcnt_d = '0;
    end else if (w_xfer) begin
      dcnt_d = (dcnt_q == cfg_q.decim) ? '0 : dcnt_q + DECIM_WIDTH'(1);
    end
  end

  // Credit: everything the FIFO and pipeline will hold after this edge must
  // leave room for one more beat accepted during the cycle of tready lag
  assign w_rd = m_axis_tvalid_o && m_axis_tready_i;

  always_comb begin
    w_credit = CRD_W'(w_fifo_cnt)
             + CRD_W'(s2_valid_q)
             - CRD_W'(w_rd)
             + CRD_W'(w_keep)
             + CRD_W'(s1_valid_q);
    s_tready_d = (w_credit <= CRD_W'(FIFO_DEPTH - 2));
  end

  // --------------------------------------------------------------------------
  // Sequential logic
  // --------------------------------------------------------------------------

  // Shadow configuration, decimation phase and registered upstream ready
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cfg_q      <= '0;
      dcnt_q     <= '0;
      s_tready_q <= 1'b0;
    end else begin
      if (cfg_load_i) begin
        cfg_q.shift <= shift_cfg_i;
        cfg_q.decim <= decim_cfg_i;
      end
      dcnt_q     <= dcnt_d;
      s_tready_q <= s_tready_d;
    end
  end

  // Stage 1: add the rounding constant to kept samples
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_valid_q <= 1'b0;
      s1_sum_q   <= '0;
      s1_shift_q <= '0;
    end else begin
      s1_valid_q <= w_keep;
      if (w_keep) begin
        s1_sum_q   <= w_sum;
        s1_shift_q <= cfg_q.shift;
      end
    end
  end

  // Stage 2: shift and saturate into the narrow output word
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        if (w_hi) begin
          s2_data_q <= SAT_MAX[OUT_WIDTH-1:0];
        end else if (w_lo) begin
          s2_data_q <= SAT_MIN[OUT_WIDTH-1:0];
        end else begin
          s2_data_q <= w_shifted[OUT_WIDTH-1:0];
        end
      end
    end
  end

  // Sticky saturation flag; a config load starts a fresh observation window
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sat_flag_q <= 1'b0;
    end else if (cfg_load_i) begin
      sat_flag_q <= 1'b0;
    end else if (w_clip) begin
      sat_flag_q <= 1'b1;
    end
  end

`ifdef FIR_DOUT_SHAPER_STAT_EN
  logic [15:0] sat_cnt_q;

  // Saturating count of clipped samples, cleared with the flag
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sat_cnt_q <= '0;
    end else if (cfg_load_i) begin
      sat_cnt_q <= '0;
    end else if (w_clip && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_q <= sat_cnt_q + 16'd1;
    end
  end

  assign sat_cnt_o = sat_cnt_q;
`endif

  // --------------------------------------------------------------------------
  // Output FIFO
  // --------------------------------------------------------------------------
  fir_shaper_fifo #(
    .DATA_WIDTH (OUT_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .wr_en_i   (s2_valid_q),
    .wr_data_i (s2_data_q),
    .rd_en_i   (m_axis_tready_i),
    .rd_data_o (m_axis_tdata_o),
    .valid_o   (m_axis_tvalid_o),
    .count_o   (w_fifo_cnt)
  );

  assign s_axis_tready_o = s_tready_q;
  assign sat_flag_o      = sat_flag_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_dout_shaper.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_dout_shaper
// Description : Scoreboard bench for fir_dout_shaper. Drivers push the
//               hand-computed output for every kept sample into a queue at
//               acceptance; an independent monitor pops and compares on each
//               output beat.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_dout_shaper;
  import fir_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_load = 1'b0;
  logic [5:0]  shift_cfg = '0;
  logic [7:0]  decim_cfg = '0;
  logic [47:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [15:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        sat_flag;
`ifdef FIR_DOUT_SHAPER_STAT_EN
  logic [15:0] sat_cnt;
`endif

  fir_dout_shaper dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .cfg_load_i      (cfg_load),
    .shift_cfg_i     (shift_cfg),
    .decim_cfg_i     (decim_cfg),
    .s_axis_tdata_i  (s_tdata),
    .s_axis_tvalid_i (s_tvalid),
    .s_axis_tready_o (s_tready),
    .m_axis_tdata_o  (m_tdata),
    .m_axis_tvalid_o (m_tvalid),
    .m_axis_tready_i (m_tready),
    .sat_flag_o      (sat_flag)
`ifdef FIR_DOUT_SHAPER_STAT_EN
    ,
    .sat_cnt_o       (sat_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic signed [15:0] data;
    int                 edge_n;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   chk_lat = 1'b0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every output beat must match the oldest outstanding expectation
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got %0d expected none", $signed(m_tdata));
      end else begin
        e = exp_q.pop_front();
        check("out_data", $signed(m_tdata), e.data);
        if (chk_lat) check("out_latency", cyc - e.edge_n, 2);
      end
    end
  end

  // Offer one sample; optionally pulse cfg_load on its acceptance edge
  task automatic send_x(input logic signed [47:0] d, input bit keep,
                        input logic signed [15:0] e, input bit ld,
                        input int sh, input int dc);
    int n = 0;
    s_tdata  = d;
    s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!s_tready) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: tready %0d expected 1", s_tready);
      s_tvalid = 1'b0;
    end else begin
      if (keep) exp_q.push_back('{data: e, edge_n: cyc + 1});
      if (ld) begin
        shift_cfg = sh[5:0];
        decim_cfg = dc[7:0];
        cfg_load  = 1'b1;
      end
      @(posedge clk);
      #1;
      s_tvalid = 1'b0;
      cfg_load = 1'b0;
    end
  endtask

  task automatic send(input logic signed [47:0] d, input bit keep,
                      input logic signed [15:0] e);
    send_x(d, keep, e, 1'b0, 0, 0);
  endtask

  task automatic load(input int sh, input int dc);
    shift_cfg = sh[5:0];
    decim_cfg = dc[7:0];
    cfg_load  = 1'b1;
    @(posedge clk);
    #1;
    cfg_load  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d outputs outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("rst_s_tready", s_tready, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tdata",  m_tdata,  0);
    check("rst_sat_flag", sat_flag, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("tready_before_edge", s_tready, 0);
    @(negedge clk);
    check("tready_after_edge", s_tready, 1);
    @(posedge clk);
    #1 m_tready = 1'b1;

    // ---- passthrough with latency check ----
    load(0, 0);
    chk_lat = 1'b1;
    send(5, 1, 5);
    send(-3, 1, -3);
    send(32767, 1, 32767);
    drain();
    chk_lat = 1'b0;

    // ---- rounding: (x + 8) >>> 4 ----
    load(4, 0);
    send(48'sh18, 1, 2);
    send(48'sh17, 1, 1);
    send(-48'sh18, 1, -1);
    drain();
    check("round_no_sat", sat_flag, 0);

    // ---- saturation, sticky flag, clear on load ----
    load(0, 0);
    send(40000, 1, FIR_OUT_MAX);
    send(-40000, 1, FIR_OUT_MIN);
    drain();
    check("sat_flag_set", sat_flag, 1);
    send(7, 1, 7);
    drain();
    check("sat_flag_sticky", sat_flag, 1);
`ifdef FIR_DOUT_SHAPER_STAT_EN
    check("sat_cnt_two", sat_cnt, 2);
`endif
    load(0, 0);
    check("sat_flag_cleared", sat_flag, 0);
`ifdef FIR_DOUT_SHAPER_STAT_EN
    check("sat_cnt_cleared", sat_cnt, 0);
`endif

    // ---- decimation 1 of 3 ----
    load(0, 2);
    for (int i = 0; i < 9; i++) send(i, (i % 3) == 0, 16'(i));
    drain();
    // phase advanced by 9 -> kept, then reload restarts the phase
    send(9, 1, 9);
    load(0, 0);
    send(10, 1, 10);
    send(11, 1, 11);
    drain();
    // sample on the load edge uses old shift=0 and does not count
    send_x(20, 1, 20, 1'b1, 1, 1);
    send(21, 1, 11);
    send(22, 0, 0);
    send(23, 1, 12);
    drain();
    check("decim_no_sat", sat_flag, 0);

    // ---- backpressure ----
    load(0, 0);
    m_tready = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(100 + i, 1, 16'(100 + i));
      end
      begin
        repeat (10) @(posedge clk);
        #2;
        check("bp_accept_le4", exp_q.size() <= 4, 1);
        check("bp_accept_cnt", exp_q.size(), 3);
        check("bp_tready_low", s_tready, 0);
        check("bp_tvalid", m_tvalid, 1);
        check("bp_head_stable0", $signed(m_tdata), 100);
        @(negedge clk);
        check("bp_head_stable1", $signed(m_tdata), 100);
        @(posedge clk);
        #1 m_tready = 1'b1;
      end
    join
    drain();

    // ---- asynchronous reset mid-stream ----
    m_tready = 1'b0;
    send(200, 1, 200);
    send(201, 1, 201);
    send(202, 1, 202);
    repeat (4) @(posedge clk);
    #1;
    check("pre_rst_tvalid", m_tvalid, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_tvalid_drop", m_tvalid, 0);
    check("rst_tready_drop", s_tready, 0);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_tready = 1'b1;
    send(300, 1, 300);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
